// File: rtl/id2exe_skid_buffer.sv
// ID->EXE receiving buffer: two-entry skid buffer (main + skid) with a
// registered ready, flush support, occupancy and a saturating stall counter.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 on the same side (in_fire = valid_i & ready_o, out_fire = valid_o &
// ready_i). A producer never withdraws a valid payload on its own. ready_o and
// valid_o are decoded from registered state only, so neither depends
// combinationally on any input.

package id2exe_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] op3;
        logic [4:0]  rd;
        logic [7:0]  exe_ctrl;
        logic [3:0]  mem_ctrl;
        logic [3:0]  csr_ctrl;
        logic [1:0]  gpr_ctrl;
        logic [2:0]  pc_ctrl;
    } id2exe_t;

endpackage

module id2exe_skid_buffer #(
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  id2exe_pkg::id2exe_t        id2exe_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output id2exe_pkg::id2exe_t        id2exe_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    input  logic                       flush_i,
    output logic [1:0]                 occupancy_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o,
    output logic [1:0]                 state_o
);

    import id2exe_pkg::*;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    id2exe_t                    main_q, main_d;
    id2exe_t                    skid_q, skid_d;
    logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

    logic in_fire;
    logic out_fire;

    // Handshake outputs are pure decodes of the state register.
    always_comb begin
        ready_o     = (state_q != FULL);
        valid_o     = (state_q == ONE) || (state_q == FULL);
        id2exe_o    = valid_o ? main_q : '0;
        occupancy_o = (state_q == FULL) ? 2'd2 : ((state_q == ONE) ? 2'd1 : 2'd0);
        state_o     = state_q;
        stall_cnt_o = stall_q;
        in_fire     = valid_i && ready_o;
        out_fire    = valid_o && ready_i;
    end

    // Next-state and entry updates; payload is captured only on in_fire so an
    // idle id2exe_i never reaches any register.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = id2exe_i;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = id2exe_i;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_d  = id2exe_i;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Flush wins over everything: a head taken this cycle stays with EXE,
        // the skid entry and any incoming payload are dropped.
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    // Stall counter: upstream offered a payload that could not be accepted.
    always_comb begin
        stall_d = stall_q;
        if (valid_i && !ready_o && (stall_q != {STALL_CNT_WIDTH{1'b1}})) begin
            stall_d = stall_q + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // State, entries and counter registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_id2exe_skid_buffer.sv
// Self-checking bench for id2exe_skid_buffer: queue-based reference model,
// per-cycle output checks and an expected-payload scoreboard.
module tb_id2exe_skid_buffer;

    import id2exe_pkg::*;

    localparam int CW = 4;
    localparam int PW = $bits(id2exe_t);

    // clock / reset
    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    id2exe_t         id2exe_i;
    logic            valid_i;
    logic            ready_o;
    id2exe_t         id2exe_o;
    logic            valid_o;
    logic            ready_i;
    logic            flush_i;
    logic [1:0]      occupancy_o;
    logic [CW-1:0]   stall_cnt_o;
    logic [1:0]      state_o;

    id2exe_skid_buffer #(.STALL_CNT_WIDTH(CW)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .id2exe_i    (id2exe_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .id2exe_o    (id2exe_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .flush_i     (flush_i),
        .occupancy_o (occupancy_o),
        .stall_cnt_o (stall_cnt_o),
        .state_o     (state_o)
    );

    // scoreboard
    logic [PW-1:0] exp_q[$];
    int            exp_stall;
    int            n_checks;
    int            n_errors;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = exp_q.size();
        check("valid_o", 256'(valid_o), 256'(sz > 0));
        check("ready_o", 256'(ready_o), 256'(sz < 2));
        check("occupancy_o", 256'(occupancy_o), 256'(sz));
        check("stall_cnt_o", 256'(stall_cnt_o), 256'(exp_stall));
        if (sz == 0) check("id2exe_o_zero", 256'(id2exe_o), 256'(0));
    endtask

    function automatic id2exe_t make_payload(input logic [31:0] pc, input logic [4:0] rd);
        id2exe_t p;
        p.pc       = pc;
        p.op1      = $urandom;
        p.op2      = $urandom;
        p.op3      = $urandom;
        p.rd       = rd;
        p.exe_ctrl = 8'($urandom_range(0, 255));
        p.mem_ctrl = 4'($urandom_range(0, 15));
        p.csr_ctrl = 4'($urandom_range(0, 15));
        p.gpr_ctrl = 2'($urandom_range(0, 3));
        p.pc_ctrl  = 3'($urandom_range(0, 7));
        return p;
    endfunction

    // driver: check the state left by the previous edge, drive this cycle's
    // inputs, then advance the model to what the next edge must produce
    task automatic do_cycle(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                            input logic rdy, input logic fl);
        id2exe_t       p;
        logic          m_ready, m_valid;
        logic [PW-1:0] head;
        p = make_payload(v ? pc : $urandom, v ? rd : 5'($urandom_range(0, 31)));
        @(negedge clk_i);
        check_outputs();
        id2exe_i = p;
        valid_i  = v;
        ready_i  = rdy;
        flush_i  = fl;
        m_ready  = exp_q.size() < 2;
        m_valid  = exp_q.size() > 0;
        if (m_valid && rdy) begin
            head = exp_q.pop_front();
            check("out_payload", 256'(id2exe_o), 256'(head));
        end
        if (v && !m_ready && exp_stall < (1 << CW) - 1) exp_stall++;
        if (fl) exp_q.delete();
        else if (v && m_ready) exp_q.push_back(p);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 32'h0, 5'd0, rdy, 1'b0);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 10) begin
            do_cycle(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
            budget++;
        end
        check("drain_done", 256'(exp_q.size()), 256'(0));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_stall = 0;
        id2exe_i  = '0;
        valid_i   = 1'b0;
        ready_i   = 1'b0;
        flush_i   = 1'b0;

        // reset state
        #12;
        check("rst_valid", 256'(valid_o), 256'(0));
        check("rst_ready", 256'(ready_o), 256'(1));
        check("rst_occ", 256'(occupancy_o), 256'(0));
        check("rst_stall", 256'(stall_cnt_o), 256'(0));
        check("rst_data", 256'(id2exe_o), 256'(0));
        @(negedge clk_i);
        rstn_i = 1'b1;

        // 1. streaming
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 32'h1000 + 32'(4 * i), 5'(i + 1), 1'b1, 1'b0);
        drain();
        idle(1, 1'b1);

        // 2. back-pressure: two accepted, third offer stalls 3 cycles
        do_cycle(1'b1, 32'h2000, 5'd5, 1'b0, 1'b0);
        do_cycle(1'b1, 32'h2004, 5'd6, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 32'h2008, 5'd7, 1'b0, 1'b0);
        do_cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        check("bp_stall3", 256'(exp_stall), 256'(3));
        drain();
        idle(1, 1'b1);

        // 3. flush while FULL with simultaneous in/out
        do_cycle(1'b1, 32'h3000, 5'd8, 1'b0, 1'b0);
        do_cycle(1'b1, 32'h3004, 5'd9, 1'b0, 1'b0);
        do_cycle(1'b1, 32'h3008, 5'd10, 1'b1, 1'b1);
        idle(2, 1'b1);

        // 4. simultaneous in/out while ONE
        do_cycle(1'b1, 32'h4000, 5'd11, 1'b0, 1'b0);
        do_cycle(1'b1, 32'h4004, 5'd12, 1'b1, 1'b0);
        do_cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        drain();

        // 5. asynchronous reset while FULL
        do_cycle(1'b1, 32'h5000, 5'd13, 1'b0, 1'b0);
        do_cycle(1'b1, 32'h5004, 5'd14, 1'b0, 1'b0);
        do_cycle(1'b1, 32'h5008, 5'd15, 1'b0, 1'b0);
        @(posedge clk_i);
        #2;
        check("pre_rst_occ", 256'(occupancy_o), 256'(2));
        rstn_i  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        flush_i = 1'b0;
        #1;
        check("arst_valid", 256'(valid_o), 256'(0));
        check("arst_ready", 256'(ready_o), 256'(1));
        check("arst_occ", 256'(occupancy_o), 256'(0));
        check("arst_stall", 256'(stall_cnt_o), 256'(0));
        check("arst_data", 256'(id2exe_o), 256'(0));
        exp_q.delete();
        exp_stall = 0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        do_cycle(1'b1, 32'h5100, 5'd16, 1'b1, 1'b0);
        drain();

        // 6. stall counter saturation
        do_cycle(1'b1, 32'h6000, 5'd17, 1'b0, 1'b0);
        do_cycle(1'b1, 32'h6004, 5'd18, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) do_cycle(1'b1, 32'h6008, 5'd19, 1'b0, 1'b0);
        do_cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        check("sat_stall", 256'(stall_cnt_o), 256'((1 << CW) - 1));
        drain();

        // random traffic
        for (int i = 0; i < 200; i++)
            do_cycle(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        drain();
        idle(1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
